// File: rtl/adc_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : adc_scan_ctrl
// Description : Round-robin flash-ADC scan sequencer. Selects each enabled
//               channel, waits for the mux to settle, averages 2^AVG_LOG2
//               codes and hands the result out over valid/ready.
//               Optional feature macro: ADC_SCAN_WINDOW_ALARM_EN (window alarm).
// Revision    : 1.0 - initial release
// ============================================================================
module adc_scan_ctrl #(
    parameter int NCH        = 4,
    parameter int CHW        = 2,
    parameter int SETTLE_CYC = 3,
    parameter int AVG_LOG2   = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enable,
    input  logic [NCH-1:0] ch_mask,
    input  logic [7:0]     adc_code,
    output logic [CHW-1:0] mux_sel,
    output logic           sample_strobe,
    output logic           busy,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [CHW-1:0] res_ch,
`ifdef ADC_SCAN_WINDOW_ALARM_EN
    input  logic [7:0]     win_lo,
    input  logic [7:0]     win_hi,
    output logic           res_alarm,
`endif
    output logic [7:0]     res_data
);

    localparam int             c_ACCW      = 8 + AVG_LOG2;
    localparam int             c_SCW       = AVG_LOG2 + 1;
    localparam int             c_STW       = $clog2(SETTLE_CYC) + 1;
    localparam logic [c_SCW-1:0] c_NSAMP_M1  = c_SCW'((1 << AVG_LOG2) - 1);
    localparam logic [c_STW-1:0] c_SETTLE_M1 = c_STW'(SETTLE_CYC - 1);
    localparam logic [CHW-1:0]   c_LAST_CH   = CHW'(NCH - 1);
    localparam logic [CHW:0]     c_NCH_EXT   = (CHW + 1)'(NCH);

    generate
        if (CHW != $clog2(NCH)) begin : g_bad_chw
            $error("adc_scan_ctrl: CHW must equal clog2(NCH)");
        end
        if (NCH < 2 || NCH > 16) begin : g_bad_nch
            $error("adc_scan_ctrl: NCH must be 2..16");
        end
        if (SETTLE_CYC < 1) begin : g_bad_settle
            $error("adc_scan_ctrl: SETTLE_CYC must be >= 1");
        end
        if (AVG_LOG2 < 0 || AVG_LOG2 > 4) begin : g_bad_avg
            $error("adc_scan_ctrl: AVG_LOG2 must be 0..4");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_RESULT = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CHW-1:0]     last_ch_q, last_ch_d;
    logic [CHW-1:0]     mux_sel_q, mux_sel_d;
    logic [c_ACCW-1:0]  acc_q, acc_d;
    logic [c_STW-1:0]   settle_q, settle_d;
    logic [c_SCW-1:0]   samp_q, samp_d;
    logic               alarm_q, alarm_d;

    logic               w_found;
    logic [CHW-1:0]     w_next_ch;
    logic [CHW:0]       w_sum;
    logic [CHW-1:0]     w_idx;
    logic [7:0]         w_avg_next;
    logic               w_more;

    // Search downward so the closest set bit after last_ch wins.
    always_comb begin
        w_found   = 1'b0;
        w_next_ch = last_ch_q;
        w_sum     = '0;
        w_idx     = '0;
        for (int i = NCH; i >= 1; i--) begin
            w_sum = {1'b0, last_ch_q} + (CHW + 1)'(i);
            if (w_sum >= c_NCH_EXT) begin
                w_sum = w_sum - c_NCH_EXT;
            end
            w_idx = w_sum[CHW-1:0];
            if (ch_mask[w_idx]) begin
                w_found   = 1'b1;
                w_next_ch = w_idx;
            end
        end
    end

    assign w_more = enable && (ch_mask != '0);

    always_comb begin
        state_d    = state_q;
        last_ch_d  = last_ch_q;
        mux_sel_d  = mux_sel_q;
        acc_d      = acc_q;
        settle_d   = settle_q;
        samp_d     = samp_q;
        alarm_d    = alarm_q;
        w_avg_next = '0;
        case (state_q)
            S_IDLE: begin
                if (w_more) begin
                    state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                if (w_found) begin
                    mux_sel_d = w_next_ch;
                    last_ch_d = w_next_ch;
                    acc_d     = '0;
                    settle_d  = c_SETTLE_M1;
                    samp_d    = '0;
                    state_d   = S_SETTLE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = S_SAMPLE;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            S_SAMPLE: begin
                acc_d      = acc_q + c_ACCW'(adc_code);
                w_avg_next = acc_d[AVG_LOG2 +: 8];
                if (samp_q == c_NSAMP_M1) begin
                    state_d = S_RESULT;
`ifdef ADC_SCAN_WINDOW_ALARM_EN
                    // Latched with the final average so it stays paired with res_data.
                    alarm_d = (w_avg_next < win_lo) || (w_avg_next > win_hi);
`endif
                end else begin
                    samp_d = samp_q + 1'b1;
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    alarm_d = 1'b0;
                    state_d = w_more ? S_SELECT : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            last_ch_q <= c_LAST_CH;
            mux_sel_q <= '0;
            acc_q     <= '0;
            settle_q  <= '0;
            samp_q    <= '0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_ch_q <= last_ch_d;
            mux_sel_q <= mux_sel_d;
            acc_q     <= acc_d;
            settle_q  <= settle_d;
            samp_q    <= samp_d;
            alarm_q   <= alarm_d;
        end
    end

    assign mux_sel       = mux_sel_q;
    assign sample_strobe = (state_q == S_SAMPLE);
    assign busy          = (state_q != S_IDLE);
    assign res_valid     = (state_q == S_RESULT);
    assign res_ch        = res_valid ? mux_sel_q : '0;
    assign res_data      = res_valid ? acc_q[AVG_LOG2 +: 8] : 8'd0;
`ifdef ADC_SCAN_WINDOW_ALARM_EN
    assign res_alarm     = alarm_q;
`else
    logic w_unused;
    assign w_unused = ^{alarm_d, w_avg_next};
`endif

endmodule
`default_nettype wire

// File: doc/adc_scan_ctrl.md
Name: adc_scan_ctrl

Overview:
- Sequencer for the 8-bit flash ADC behavioural model in the mixed-signal testbench.
- Scans a set of analog channels round-robin, drives the analog mux select, and waits a programmable settle time.
- Captures and averages 2^AVG_LOG2 ADC codes per channel, then presents each averaged result on a valid/ready output.
- Sits between the analog front-end mux / flash ADC and the digital consumer (DSP or bus-side FIFO).

Parameters:
- NCH, 4, number of analog channels (2..16).
- CHW, 2, channel index width, must equal clog2(NCH).
- SETTLE_CYC, 3, mux settle cycles after a select change (>=1).
- AVG_LOG2, 2, log2 of samples averaged per result (0..4).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- enable  in  1  scan enable, level-sensitive
- ch_mask  in  NCH  channels to include in scan; bit i = channel i
- adc_code  in  8  flash ADC output code (combinational from vin)
- mux_sel  out  CHW  analog mux channel select
- sample_strobe  out  1  high in every cycle whose adc_code is accumulated
- busy  out  1  high in any state other than IDLE
- res_valid  out  1  averaged result available
- res_ready  in  1  consumer accepts result
- res_ch  out  CHW  channel of current result
- res_data  out  8  averaged code

Behaviour:
- Reset: all outputs 0, state=IDLE, last_ch=NCH-1 (so first served channel is lowest set mask bit ≥0), accumulator and counters 0.
- States: IDLE, SELECT, SETTLE, SAMPLE, RESULT.
- IDLE:
  - If enable=1 and ch_mask!=0, go to SELECT.
  - Otherwise stay; ch_mask=0 with enable=1 keeps IDLE and busy=0.
- SELECT, 1 cycle:
  - Pick the next set bit of ch_mask strictly after last_ch, wrapping modulo NCH. A single set bit selects the same channel each pass.
  - Register it to mux_sel and last_ch, clear the accumulator, load settle counter with SETTLE_CYC-1, go to SETTLE.
  - ch_mask is sampled only here; changes elsewhere take effect at the next SELECT.
- SETTLE: exactly SETTLE_CYC cycles, then SAMPLE.
- SAMPLE:
  - Exactly 2^AVG_LOG2 consecutive cycles, sample_strobe=1 in each.
  - At each rising edge, acc += adc_code; acc width 8+AVG_LOG2, never overflows.
  - After the last sample, go to RESULT.
- RESULT:
  - res_valid=1, res_data=acc>>AVG_LOG2 (truncating), res_ch=mux_sel. Both held stable while res_valid=1 and res_ready=0.
  - Transfer occurs on an edge with res_valid&res_ready. res_valid drops the following cycle unless the next result is already valid; it is not, since the minimum pass is ≥3 cycles.
  - After transfer: enable=1 and ch_mask!=0 -> SELECT; else -> IDLE.
- Backpressure stalls the scan in RESULT; no sample is taken and no result is dropped or overwritten.
- Latency: res_valid rises exactly 1+SETTLE_CYC+2^AVG_LOG2 cycles after the first SELECT cycle. With defaults: 8 cycles. Back-to-back throughput with res_ready=1 is one result per 1+SETTLE_CYC+2^AVG_LOG2+1 cycles.
- enable deasserted mid-pass (SELECT/SETTLE/SAMPLE/RESULT): the current channel completes and delivers its result, then IDLE.
- rst mid-pass: immediate return to reset values at that edge; any pending result is discarded.
- mux_sel holds its last value in IDLE.

Optional Feature:
- Macro: ADC_SCAN_WINDOW_ALARM_EN.
- Defined:
  - Adds inputs win_lo[7:0] and win_hi[7:0], and output res_alarm (1 bit, reset 0).
  - res_alarm is computed in RESULT alongside res_data: 1 when res_data<win_lo or res_data>win_hi.
  - res_alarm is held with res_data under backpressure and cleared with res_valid.
  - win_lo>win_hi flags every result.
- Undefined: the ports and logic are absent; behaviour otherwise identical.

Test Plan:
- Defaults, ch_mask=4'b1111, enable=1, res_ready=1, adc_code held per channel at 10,20,30,40 -> results on ch 0,1,2,3,0 with data 10,20,30,40,10; first res_valid 8 cycles after first SELECT; one result every 9 cycles.
- Averaging: AVG_LOG2=2, samples 100,101,102,104 on ch 0 -> res_data=101 (407>>2, truncated).
- Sparse mask 4'b1010, reset state -> order 1,3,1,3; mask changed to 4'b0100 during SETTLE of ch 3 -> ch 3 completes, next channel is 2.
- Backpressure: res_ready=0 for 20 cycles at RESULT -> res_valid, res_ch, res_data stable, sample_strobe=0, mux_sel unchanged; release -> single transfer, then SELECT.
- enable dropped during SAMPLE -> result still delivered, then IDLE, busy=0. Separately, rst asserted during SETTLE -> next cycle all outputs 0 and next scan starts at ch 0.
- With ADC_SCAN_WINDOW_ALARM_EN, win_lo=50, win_hi=200, averages 49/50/200/201 -> res_alarm 1/0/0/1.
